// File: rtl/barril_ctrl.sv
// barril_ctrl: barrel object controller for the Donkey Kong VGA pipeline.
// Keeps up to NUM_BARRILES barrel slots, spawns/moves them once per frame and
// maps the VGA scan position onto sprite-local ROM coordinates.
// Optional feature macro: BARRIL_MIRROR_EN (mirror leftward barrels horizontally).
module barril_ctrl #(
    parameter int NUM_BARRILES = 4,
    parameter int SPAWN_PERIOD = 120,
    parameter int SPEED        = 2,
    parameter int SPAWN_X      = 16,
    parameter int SPAWN_Y      = 64,
    parameter int X_MAX        = 624,
    parameter int ROW_STEP     = 48,
    parameter int Y_MAX        = 464
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       spawn_en,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [9:0] horz,
    output logic [9:0] vert,
    output logic       sprite_req,
    input  logic [1:0] draw_barril_in,
    output logic [1:0] barril_px,
    output logic       barril_px_valid,
    output logic [2:0] active_count
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // 11-bit copies so that edge/bottom comparisons never overflow
    localparam logic [10:0] SPEED_W    = 11'(SPEED);
    localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
    localparam logic [10:0] ROW_STEP_W = 11'(ROW_STEP);
    localparam logic [10:0] Y_MAX_W    = 11'(Y_MAX);
    localparam logic [9:0]  SPEED_10    = 10'(SPEED);
    localparam logic [9:0]  X_MAX_10    = 10'(X_MAX);
    localparam logic [9:0]  ROW_STEP_10 = 10'(ROW_STEP);
    localparam logic [9:0]  SPAWN_X_10  = 10'(SPAWN_X);
    localparam logic [9:0]  SPAWN_Y_10  = 10'(SPAWN_Y);

    // Number of live slots
    function automatic logic [2:0] popcount(input logic [NUM_BARRILES-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < NUM_BARRILES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Slot state
    logic [NUM_BARRILES-1:0] alive_q, alive_d;
    logic [NUM_BARRILES-1:0] dir_q, dir_d;
    logic [9:0]              x_q [NUM_BARRILES];
    logic [9:0]              x_d [NUM_BARRILES];
    logic [9:0]              y_q [NUM_BARRILES];
    logic [9:0]              y_d [NUM_BARRILES];
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

    // Pipeline state
    logic [9:0] horz_q, horz_d;
    logic [9:0] vert_q, vert_d;
    logic       sprite_req_q, sprite_req_d;
    logic [1:0] barril_px_q, barril_px_d;
    logic       barril_px_valid_q, barril_px_valid_d;
    logic [2:0] active_count_q, active_count_d;

    // Frame-update helpers
    logic       spawn_free_s;
    logic [2:0] spawn_idx_s;
    logic       spawn_now_s;
    logic       wrap_s;
    logic [9:0] nx_s;
    logic       ndir_s;
    logic       drop_s;

    // Pixel-path helpers
    logic [10:0] dx_s [NUM_BARRILES];
    logic [10:0] dy_s [NUM_BARRILES];
    logic        hit_s;
    logic [3:0]  hit_dx_s;
    logic [3:0]  hit_dy_s;
`ifdef BARRIL_MIRROR_EN
    logic        hit_dir_s;
`endif

    // Find the lowest-index dead slot (descending scan, last match wins)
    always_comb begin
        spawn_free_s = 1'b0;
        spawn_idx_s  = 3'd0;
        for (int i = NUM_BARRILES - 1; i >= 0; i--) begin
            if (!alive_q[i]) begin
                spawn_free_s = 1'b1;
                spawn_idx_s  = 3'(i);
            end else begin
                spawn_free_s = spawn_free_s;
            end
        end
    end

    // Per-frame spawn counter, spawn and movement of every slot
    always_comb begin
        alive_d     = alive_q;
        dir_d       = dir_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        wrap_s      = 1'b0;
        spawn_now_s = 1'b0;
        nx_s        = 10'd0;
        ndir_s      = 1'b0;
        drop_s      = 1'b0;
        if (frame_tick) begin
            wrap_s = (frame_cnt_q == CNT_LAST);
            if (wrap_s) begin
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
            // a full table simply drops the spawn
            spawn_now_s = wrap_s & spawn_en & spawn_free_s;
            for (int i = 0; i < NUM_BARRILES; i++) begin
                if (spawn_now_s && (spawn_idx_s == 3'(i))) begin
                    // freshly spawned slots hold still for this tick
                    alive_d[i] = 1'b1;
                    dir_d[i]   = 1'b0;
                    x_d[i]     = SPAWN_X_10;
                    y_d[i]     = SPAWN_Y_10;
                end else if (alive_q[i]) begin
                    drop_s = 1'b0;
                    ndir_s = dir_q[i];
                    if (!dir_q[i]) begin
                        if (({1'b0, x_q[i]} + SPEED_W) > X_MAX_W) begin
                            nx_s   = X_MAX_10;
                            ndir_s = 1'b1;
                            drop_s = 1'b1;
                        end else begin
                            nx_s = x_q[i] + SPEED_10;
                        end
                    end else begin
                        if ({1'b0, x_q[i]} < SPEED_W) begin
                            nx_s   = 10'd0;
                            ndir_s = 1'b0;
                            drop_s = 1'b1;
                        end else begin
                            nx_s = x_q[i] - SPEED_10;
                        end
                    end
                    if (drop_s) begin
                        // falling past the bottom retires the slot in place
                        if (({1'b0, y_q[i]} + ROW_STEP_W) > Y_MAX_W) begin
                            alive_d[i] = 1'b0;
                        end else begin
                            x_d[i]   = nx_s;
                            dir_d[i] = ndir_s;
                            y_d[i]   = y_q[i] + ROW_STEP_10;
                        end
                    end else begin
                        x_d[i] = nx_s;
                    end
                end else begin
                    alive_d[i] = alive_q[i];
                end
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Hit test against pre-update positions; lowest index wins
    always_comb begin
        hit_s    = 1'b0;
        hit_dx_s = 4'd0;
        hit_dy_s = 4'd0;
`ifdef BARRIL_MIRROR_EN
        hit_dir_s = 1'b0;
`endif
        for (int i = NUM_BARRILES - 1; i >= 0; i--) begin
            dx_s[i] = {1'b0, pix_x} - {1'b0, x_q[i]};
            dy_s[i] = {1'b0, pix_y} - {1'b0, y_q[i]};
            // upper bits zero means 0 <= d <= 15 (a negative result sets bit 10)
            if (alive_q[i] && (dx_s[i][10:4] == 7'd0) && (dy_s[i][10:4] == 7'd0)) begin
                hit_s    = 1'b1;
                hit_dx_s = dx_s[i][3:0];
                hit_dy_s = dy_s[i][3:0];
`ifdef BARRIL_MIRROR_EN
                hit_dir_s = dir_q[i];
`endif
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Stage 1: sprite ROM address and request
    always_comb begin
        sprite_req_d = pix_valid & hit_s;
        horz_d       = 10'd0;
        vert_d       = 10'd0;
        if (sprite_req_d) begin
`ifdef BARRIL_MIRROR_EN
            if (hit_dir_s) begin
                horz_d = {6'd0, 4'd15 - hit_dx_s};
            end else begin
                horz_d = {6'd0, hit_dx_s};
            end
`else
            horz_d = {6'd0, hit_dx_s};
`endif
            vert_d = {6'd0, hit_dy_s};
        end else begin
            horz_d = 10'd0;
            vert_d = 10'd0;
        end
    end

    // Stage 2: capture the ROM colour index and the live-slot count
    always_comb begin
        barril_px_d       = 2'b00;
        barril_px_valid_d = 1'b0;
        if (sprite_req_q) begin
            barril_px_d       = draw_barril_in;
            barril_px_valid_d = (draw_barril_in != 2'b00);
        end else begin
            barril_px_d       = 2'b00;
            barril_px_valid_d = 1'b0;
        end
        active_count_d = popcount(alive_d);
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q           <= '0;
            dir_q             <= '0;
            frame_cnt_q       <= '0;
            horz_q            <= 10'd0;
            vert_q            <= 10'd0;
            sprite_req_q      <= 1'b0;
            barril_px_q       <= 2'b00;
            barril_px_valid_q <= 1'b0;
            active_count_q    <= 3'd0;
            for (int i = 0; i < NUM_BARRILES; i++) begin
                x_q[i] <= 10'd0;
                y_q[i] <= 10'd0;
            end
        end else begin
            alive_q           <= alive_d;
            dir_q             <= dir_d;
            frame_cnt_q       <= frame_cnt_d;
            horz_q            <= horz_d;
            vert_q            <= vert_d;
            sprite_req_q      <= sprite_req_d;
            barril_px_q       <= barril_px_d;
            barril_px_valid_q <= barril_px_valid_d;
            active_count_q    <= active_count_d;
            for (int i = 0; i < NUM_BARRILES; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign horz            = horz_q;
    assign vert            = vert_q;
    assign sprite_req      = sprite_req_q;
    assign barril_px       = barril_px_q;
    assign barril_px_valid = barril_px_valid_q;
    assign active_count    = active_count_q;

endmodule

// File: tb/tb_barril_ctrl.sv
// Self-checking bench for barril_ctrl: table-driven pixel probes through a
// scoreboard queue plus hand-written frame-update sequences.
module tb_barril_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, spawn_en, pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [1:0] draw_barril_in;

    logic [9:0] horz1, vert1, horz2, vert2;
    logic       req1, req2, pv1, pv2;
    logic [1:0] px1, px2;
    logic [2:0] act1, act2;

    always #5 clk = ~clk;

    barril_ctrl u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn_en(spawn_en),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .horz(horz1), .vert(vert1), .sprite_req(req1),
        .draw_barril_in(draw_barril_in), .barril_px(px1),
        .barril_px_valid(pv1), .active_count(act1)
    );

    // short spawn period so several barrels can overlap
    barril_ctrl #(.SPAWN_PERIOD(4)) u_dut_fast (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .spawn_en(spawn_en),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .horz(horz2), .vert(vert2), .sprite_req(req2),
        .draw_barril_in(draw_barril_in), .barril_px(px2),
        .barril_px_valid(pv2), .active_count(act2)
    );

`ifdef BARRIL_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // single-barrel reference model for the default-parameter instance
    bit m_alive, m_dir;
    int m_x, m_y, m_cnt;

    typedef struct {
        int px; int py; bit valid; int rom;
        bit er; int eh; int ev; int epx; bit epv; int grp;
    } vec_t;
    vec_t tbl[11];

    typedef struct {
        string nm; bit er; int eh; int ev; int epx; bit epv;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_alive = 1'b0; m_dir = 1'b0; m_x = 0; m_y = 0; m_cnt = 0;
    endtask

    task automatic model_tick();
        bit wrap;
        wrap  = (m_cnt == 119);
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap && spawn_en && !m_alive) begin
            m_alive = 1'b1; m_x = 16; m_y = 64; m_dir = 1'b0;
        end else if (m_alive) begin
            if (!m_dir) begin
                if (m_x + 2 > 624) begin
                    if (m_y + 48 > 464) m_alive = 1'b0;
                    else begin m_x = 624; m_dir = 1'b1; m_y += 48; end
                end else m_x += 2;
            end else begin
                if (m_x < 2) begin
                    if (m_y + 48 > 464) m_alive = 1'b0;
                    else begin m_x = 0; m_dir = 1'b0; m_y += 48; end
                end else m_x -= 2;
            end
        end
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_tick();
    endtask

    // drive one pixel, push its expectation, pop and compare at N+1 / N+2
    task automatic probe(input int sel, input int px, input int py, input bit valid,
                         input bit tk, input int rom, input bit er, input int eh,
                         input int ev, input int epx, input bit epv, input string nm);
        exp_t e;
        e.nm = nm; e.er = er; e.eh = eh; e.ev = ev; e.epx = epx; e.epv = epv;
        sbq.push_back(e);
        pix_x = 10'(px); pix_y = 10'(py); pix_valid = valid; frame_tick = tk;
        @(posedge clk); #1;
        frame_tick = 1'b0; pix_valid = 1'b0;
        if (tk) model_tick();
        draw_barril_in = 2'(rom);
        e = sbq.pop_front();
        chk({e.nm, "_req"},  int'(sel == 2 ? req2 : req1), int'(e.er));
        chk({e.nm, "_horz"}, int'(sel == 2 ? horz2 : horz1), e.eh);
        chk({e.nm, "_vert"}, int'(sel == 2 ? vert2 : vert1), e.ev);
        @(posedge clk); #1;
        chk({e.nm, "_px"},   int'(sel == 2 ? px2 : px1), e.epx);
        chk({e.nm, "_pv"},   int'(sel == 2 ? pv2 : pv1), int'(e.epv));
        draw_barril_in = 2'b00;
    endtask

    task automatic apply_grp(input int g);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].grp == g)
                probe(1, tbl[i].px, tbl[i].py, tbl[i].valid, 1'b0, tbl[i].rom,
                      tbl[i].er, tbl[i].eh, tbl[i].ev, tbl[i].epx, tbl[i].epv,
                      $sformatf("tbl%0d", i));
        end
    endtask

    initial begin
        // group 0: barrel at (36,64); group 1: barrel at (100,64)
        tbl[0]  = '{36, 64, 1'b1, 3, 1'b1, 0, 0, 3, 1'b1, 0};
        tbl[1]  = '{51, 79, 1'b1, 1, 1'b1, 15, 15, 1, 1'b1, 0};
        tbl[2]  = '{52, 64, 1'b1, 3, 1'b0, 0, 0, 0, 1'b0, 0};
        tbl[3]  = '{36, 63, 1'b1, 3, 1'b0, 0, 0, 0, 1'b0, 0};
        tbl[4]  = '{40, 80, 1'b1, 3, 1'b0, 0, 0, 0, 1'b0, 0};
        tbl[5]  = '{43, 70, 1'b1, 0, 1'b1, 7, 6, 0, 1'b0, 0};
        tbl[6]  = '{103, 69, 1'b1, 3, 1'b1, 3, 5, 3, 1'b1, 1};
        tbl[7]  = '{103, 69, 1'b1, 0, 1'b1, 3, 5, 0, 1'b0, 1};
        tbl[8]  = '{99, 64, 1'b1, 3, 1'b0, 0, 0, 0, 1'b0, 1};
        tbl[9]  = '{115, 64, 1'b1, 2, 1'b1, 15, 0, 2, 1'b1, 1};
        tbl[10] = '{100, 64, 1'b0, 3, 1'b0, 0, 0, 0, 1'b0, 1};

        rst = 1'b1; frame_tick = 1'b0; spawn_en = 1'b0; pix_valid = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0; draw_barril_in = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", int'(req1), 0);
        chk("rst_horz", int'(horz1), 0);
        chk("rst_vert", int'(vert1), 0);
        chk("rst_px", int'(px1), 0);
        chk("rst_pv", int'(pv1), 0);
        chk("rst_act", int'(act1), 0);
        chk("rst_act_fast", int'(act2), 0);
        rst = 1'b0;

        // fast instance: overlap priority and full-table wrap
        spawn_en = 1'b1;
        repeat (3) do_tick();
        chk("fast_no_spawn_yet", int'(act2), 0);
        do_tick();
        chk("fast_spawn1", int'(act2), 1);
        repeat (4) do_tick();
        chk("fast_spawn2", int'(act2), 2);
        probe(2, 24, 64, 1'b1, 1'b0, 1, 1'b1, 0, 0, 1, 1'b1, "overlap_low_idx");
        probe(2, 23, 70, 1'b1, 1'b0, 1, 1'b1, 7, 6, 1, 1'b1, "overlap_slot1_only");
        repeat (4) do_tick();
        chk("fast_spawn3", int'(act2), 3);
        repeat (4) do_tick();
        chk("fast_spawn4", int'(act2), 4);
        repeat (4) do_tick();
        chk("fast_full_wrap", int'(act2), 4);
        probe(2, 48, 64, 1'b1, 1'b0, 2, 1'b1, 0, 0, 2, 1'b1, "full_slot0");
        probe(2, 47, 64, 1'b1, 1'b0, 2, 1'b1, 7, 0, 2, 1'b1, "full_slot1");
        probe(2, 24, 64, 1'b1, 1'b0, 2, 1'b1, 0, 0, 2, 1'b1, "full_slot3");
        probe(2, 23, 64, 1'b1, 1'b0, 2, 1'b0, 0, 0, 0, 1'b0, "full_gap");

        // default instance: spawn timing and movement
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst2_act", int'(act1), 0);
        spawn_en = 1'b1;
        repeat (119) do_tick();
        chk("spawn_before_wrap", int'(act1), 0);
        do_tick();
        chk("spawn_at_wrap", int'(act1), 1);
        spawn_en = 1'b0;
        probe(1, 16, 64, 1'b1, 1'b0, 2, 1'b1, 0, 0, 2, 1'b1, "spawn_pos");
        probe(1, 15, 64, 1'b1, 1'b0, 2, 1'b0, 0, 0, 0, 1'b0, "spawn_left_miss");
        repeat (10) do_tick();
        apply_grp(0);
        repeat (32) do_tick();
        apply_grp(1);

        // tick and pixel together: hit uses the pre-update position
        probe(1, 100, 64, 1'b1, 1'b1, 1, 1'b1, 0, 0, 1, 1'b1, "tick_same_cycle");
        probe(1, 101, 64, 1'b1, 1'b0, 1, 1'b0, 0, 0, 0, 1'b0, "after_tick_old");
        probe(1, 102, 64, 1'b1, 1'b0, 1, 1'b1, 0, 0, 1, 1'b1, "after_tick_new");

        // right edge bounce
        for (int n = 0; n < 2000 && !m_dir; n++) do_tick();
        probe(1, 630, 112, 1'b1, 1'b0, 3, 1'b1, MIR ? 9 : 6, 0, 3, 1'b1, "bounce_horz");
        probe(1, 624, 127, 1'b1, 1'b0, 0, 1'b1, MIR ? 15 : 0, 15, 0, 1'b0, "bounce_corner");
        do_tick();
        probe(1, 637, 112, 1'b1, 1'b0, 1, 1'b1, MIR ? 0 : 15, 0, 1, 1'b1, "move_left");

        // ride down to the last row, then retire
        for (int n = 0; n < 5000 && m_y != 448; n++) do_tick();
        probe(1, m_x + 1, 450, 1'b1, 1'b0, 2, 1'b1,
              (MIR && m_dir) ? 14 : 1, 2, 2, 1'b1, "last_row");
        chk("last_row_act", int'(act1), 1);
        for (int n = 0; n < 1000 && m_alive; n++) do_tick();
        chk("retire_act", int'(act1), 0);
        probe(1, m_x, 448, 1'b1, 1'b0, 2, 1'b0, 0, 0, 0, 1'b0, "retired_miss");

        // reset in the middle of activity
        spawn_en = 1'b1;
        for (int n = 0; n < 200 && !m_alive; n++) do_tick();
        spawn_en = 1'b0;
        chk("respawn_act", int'(act1), 1);
        pix_x = 10'(m_x + 2); pix_y = 10'(m_y + 3); pix_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_req", int'(req1), 1);
        rst = 1'b1; draw_barril_in = 2'b11;
        @(posedge clk); #1;
        chk("midrst_req", int'(req1), 0);
        chk("midrst_horz", int'(horz1), 0);
        chk("midrst_vert", int'(vert1), 0);
        chk("midrst_px", int'(px1), 0);
        chk("midrst_pv", int'(pv1), 0);
        chk("midrst_act", int'(act1), 0);
        rst = 1'b0; pix_valid = 1'b0; draw_barril_in = 2'b00;
        model_reset();
        probe(1, 18, 67, 1'b1, 1'b0, 3, 1'b0, 0, 0, 0, 1'b0, "post_rst_dead");
        spawn_en = 1'b1;
        repeat (119) do_tick();
        chk("post_rst_no_spawn", int'(act1), 0);
        do_tick();
        chk("post_rst_spawn", int'(act1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
